id_ex_hazard_stage: RTL and testbench

- ID/EX pipeline register for the ARM-subset pipeline, directly downstream of IF_ID, the ControlUnit and its Multiplexer.
- Registers the decoded control signals and operands into the EX stage.
- Keeps a shadow record of destination registers for EX, MEM and WB.
- Generates forwarding selects and load-use stall/bubble controls that drive enable_pc, enable_ifid and the control-unit mux select S.

---
 rtl/id_ex_hazard_stage.sv | 217 +++++++++++++++++++++
 tb/tb_id_ex_hazard_stage.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with destination shadow tracking,
// operand forwarding selects and load-use stall control.
module id_ex_hazard_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        id_alu_op,
  input  logic [1:0]        id_am,
  input  logic              id_load,
  input  logic              id_mem_write,
  input  logic              id_mem_size,
  input  logic              id_mem_e,
  input  logic              id_rf_e,
  input  logic              id_store_cc,
  input  logic [RA_W-1:0]   id_rn,
  input  logic [RA_W-1:0]   id_rm,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_use_rn,
  input  logic              id_use_rm,
  input  logic              id_use_rd,
  input  logic [DATA_W-1:0] id_pa,
  input  logic [DATA_W-1:0] id_pb,
  input  logic [DATA_W-1:0] id_pd,
  input  logic [11:0]       id_shift_imm,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        fwd_d,
  output logic              pc_enable,
  output logic              ifid_enable,
  output logic              cu_mux_sel,
  output logic [3:0]        ex_alu_op,
  output logic [1:0]        ex_am,
  output logic              ex_load,
  output logic              ex_mem_write,
  output logic              ex_mem_size,
  output logic              ex_mem_e,
  output logic              ex_rf_e,
  output logic              ex_store_cc,
  output logic [RA_W-1:0]   ex_rd,
  output logic [DATA_W-1:0] ex_pa,
  output logic [DATA_W-1:0] ex_pb,
  output logic [DATA_W-1:0] ex_pd,
  output logic [11:0]       ex_shift_imm,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [RA_W-1:0]  R15  = '1;
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [3:0]        r_ex_alu_op;
  logic [1:0]        r_ex_am;
  logic              r_ex_load;
  logic              r_ex_mem_write;
  logic              r_ex_mem_size;
  logic              r_ex_mem_e;
  logic              r_ex_rf_e;
  logic              r_ex_store_cc;
  logic [RA_W-1:0]   r_ex_rd;
  logic [DATA_W-1:0] r_ex_pa;
  logic [DATA_W-1:0] r_ex_pb;
  logic [DATA_W-1:0] r_ex_pd;
  logic [11:0]       r_ex_shift_imm;
  logic [RA_W-1:0]   r_mem_rd;
  logic              r_mem_rf_e;
  logic [RA_W-1:0]   r_wb_rd;
  logic              r_wb_rf_e;
  logic [CNT_W-1:0]  r_stall_count;

  logic              w_ex_fwd_ok;
  logic              w_hit_rn;
  logic              w_hit_rm;
  logic              w_hit_rd;
  logic              w_stall;
  logic              w_bubble;
  logic              w_cnt_inc;

  // A load result is not ready in EX, so EX only forwards non-loads.
  function automatic logic [1:0] f_fwd(
    input logic            use_x,
    input logic [RA_W-1:0] x,
    input logic            ex_ok,
    input logic [RA_W-1:0] ex_d,
    input logic            mem_ok,
    input logic [RA_W-1:0] mem_d,
    input logic            wb_ok,
    input logic [RA_W-1:0] wb_d
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_x && (x != R15)) begin
      if (ex_ok && (ex_d == x)) begin
        sel = 2'b01;
      end else if (mem_ok && (mem_d == x)) begin
        sel = 2'b10;
      end else if (wb_ok && (wb_d == x)) begin
        sel = 2'b11;
      end
    end
    return sel;
  endfunction

  function automatic logic f_hit(
    input logic            use_x,
    input logic [RA_W-1:0] x,
    input logic [RA_W-1:0] ex_d
  );
    return use_x && (x != R15) && (x == ex_d);
  endfunction

  assign w_ex_fwd_ok = r_ex_rf_e & ~r_ex_load;

  assign fwd_a = f_fwd(id_use_rn, id_rn, w_ex_fwd_ok, r_ex_rd,
                       r_mem_rf_e, r_mem_rd, r_wb_rf_e, r_wb_rd);
  assign fwd_b = f_fwd(id_use_rm, id_rm, w_ex_fwd_ok, r_ex_rd,
                       r_mem_rf_e, r_mem_rd, r_wb_rf_e, r_wb_rd);
  assign fwd_d = f_fwd(id_use_rd, id_rd, w_ex_fwd_ok, r_ex_rd,
                       r_mem_rf_e, r_mem_rd, r_wb_rf_e, r_wb_rd);

  assign w_hit_rn = f_hit(id_use_rn, id_rn, r_ex_rd);
  assign w_hit_rm = f_hit(id_use_rm, id_rm, r_ex_rd);
  assign w_hit_rd = f_hit(id_use_rd, id_rd, r_ex_rd);

  assign w_stall   = r_ex_load & r_ex_rf_e &
                     (w_hit_rn | w_hit_rm | w_hit_rd);
  assign w_bubble  = w_stall | flush;
  assign w_cnt_inc = w_stall & ~flush & (r_stall_count != CMAX);

  // A flush discards the stalled instruction, so the front end may advance.
  assign pc_enable   = ~w_stall | flush;
  assign ifid_enable = ~w_stall | flush;
  assign cu_mux_sel  = w_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_alu_op    <= '0;
      r_ex_am        <= '0;
      r_ex_load      <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_mem_size  <= 1'b0;
      r_ex_mem_e     <= 1'b0;
      r_ex_rf_e      <= 1'b0;
      r_ex_store_cc  <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_pa        <= '0;
      r_ex_pb        <= '0;
      r_ex_pd        <= '0;
      r_ex_shift_imm <= '0;
    end else if (w_bubble) begin
      r_ex_alu_op    <= '0;
      r_ex_am        <= '0;
      r_ex_load      <= 1'b0;
      r_ex_mem_write <= 1'b0;
      r_ex_mem_size  <= 1'b0;
      r_ex_mem_e     <= 1'b0;
      r_ex_rf_e      <= 1'b0;
      r_ex_store_cc  <= 1'b0;
      r_ex_rd        <= '0;
      r_ex_pa        <= '0;
      r_ex_pb        <= '0;
      r_ex_pd        <= '0;
      r_ex_shift_imm <= '0;
    end else begin
      r_ex_alu_op    <= id_alu_op;
      r_ex_am        <= id_am;
      r_ex_load      <= id_load;
      r_ex_mem_write <= id_mem_write;
      r_ex_mem_size  <= id_mem_size;
      r_ex_mem_e     <= id_mem_e;
      r_ex_rf_e      <= id_rf_e;
      r_ex_store_cc  <= id_store_cc;
      r_ex_rd        <= id_rd;
      r_ex_pa        <= id_pa;
      r_ex_pb        <= id_pb;
      r_ex_pd        <= id_pd;
      r_ex_shift_imm <= id_shift_imm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_rd      <= '0;
      r_mem_rf_e    <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_rf_e     <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_mem_rd   <= r_ex_rd;
      r_mem_rf_e <= r_ex_rf_e;
      r_wb_rd    <= r_mem_rd;
      r_wb_rf_e  <= r_mem_rf_e;
      if (w_cnt_inc) begin
        r_stall_count <= r_stall_count + CONE;
      end
    end
  end

  assign ex_alu_op    = r_ex_alu_op;
  assign ex_am        = r_ex_am;
  assign ex_load      = r_ex_load;
  assign ex_mem_write = r_ex_mem_write;
  assign ex_mem_size  = r_ex_mem_size;
  assign ex_mem_e     = r_ex_mem_e;
  assign ex_rf_e      = r_ex_rf_e;
  assign ex_store_cc  = r_ex_store_cc;
  assign ex_rd        = r_ex_rd;
  assign ex_pa        = r_ex_pa;
  assign ex_pb        = r_ex_pb;
  assign ex_pd        = r_ex_pd;
  assign ex_shift_imm = r_ex_shift_imm;
  assign stall_count  = r_stall_count;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Bench for id_ex_hazard_stage: directed hazard scenarios plus
// randomized traffic against a producer-history reference model.
module tb_id_ex_hazard_stage;

  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [3:0]  alu;
    logic [1:0]  am;
    logic        ld;
    logic        mw;
    logic        ms;
    logic        me;
    logic        rf;
    logic        scc;
    logic [3:0]  rd;
    logic [31:0] pa;
    logic [31:0] pb;
    logic [31:0] pd;
    logic [11:0] imm;
  } ex_t;

  logic        clk;
  logic        reset;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_am;
  logic        id_load, id_mem_write, id_mem_size, id_mem_e;
  logic        id_rf_e, id_store_cc;
  logic [3:0]  id_rn, id_rm, id_rd;
  logic        id_use_rn, id_use_rm, id_use_rd;
  logic [31:0] id_pa, id_pb, id_pd;
  logic [11:0] id_shift_imm;
  logic        flush;
  logic [1:0]  fwd_a, fwd_b, fwd_d;
  logic        pc_enable, ifid_enable, cu_mux_sel;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_am;
  logic        ex_load, ex_mem_write, ex_mem_size, ex_mem_e;
  logic        ex_rf_e, ex_store_cc;
  logic [3:0]  ex_rd;
  logic [31:0] ex_pa, ex_pb, ex_pd;
  logic [11:0] ex_shift_imm;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Reference model: producers ordered by age (0 = EX, 1 = MEM, 2 = WB).
  ex_t      m_ex;
  logic [3:0] h_rd [3];
  logic       h_rf [3];
  int         m_cnt;

  id_ex_hazard_stage #(.DATA_W(32), .RA_W(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_alu_op(id_alu_op), .id_am(id_am), .id_load(id_load),
    .id_mem_write(id_mem_write), .id_mem_size(id_mem_size),
    .id_mem_e(id_mem_e), .id_rf_e(id_rf_e),
    .id_store_cc(id_store_cc),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm),
    .id_use_rd(id_use_rd),
    .id_pa(id_pa), .id_pb(id_pb), .id_pd(id_pd),
    .id_shift_imm(id_shift_imm), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_d(fwd_d),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable),
    .cu_mux_sel(cu_mux_sel),
    .ex_alu_op(ex_alu_op), .ex_am(ex_am), .ex_load(ex_load),
    .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_e(ex_mem_e), .ex_rf_e(ex_rf_e),
    .ex_store_cc(ex_store_cc), .ex_rd(ex_rd),
    .ex_pa(ex_pa), .ex_pb(ex_pb), .ex_pd(ex_pd),
    .ex_shift_imm(ex_shift_imm), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_t cur_in();
    ex_t e;
    e = '{id_alu_op, id_am, id_load, id_mem_write, id_mem_size,
          id_mem_e, id_rf_e, id_store_cc, id_rd,
          id_pa, id_pb, id_pd, id_shift_imm};
    return e;
  endfunction

  function automatic ex_t dut_ex();
    ex_t e;
    e = '{ex_alu_op, ex_am, ex_load, ex_mem_write, ex_mem_size,
          ex_mem_e, ex_rf_e, ex_store_cc, ex_rd,
          ex_pa, ex_pb, ex_pd, ex_shift_imm};
    return e;
  endfunction

  // Youngest matching producer wins; an in-flight load cannot supply data.
  function automatic logic [1:0] exp_fwd(input logic u,
                                         input logic [3:0] r);
    if (!u || r == 4'd15) return 2'b00;
    for (int a = 0; a < 3; a++) begin
      if (h_rf[a] && h_rd[a] == r) begin
        if (a == 0 && m_ex.ld) continue;
        return 2'(a + 1);
      end
    end
    return 2'b00;
  endfunction

  function automatic logic needs(input logic u, input logic [3:0] r);
    return u && r != 4'd15 && r == m_ex.rd;
  endfunction

  function automatic logic exp_stall();
    return m_ex.ld && m_ex.rf &&
           (needs(id_use_rn, id_rn) || needs(id_use_rm, id_rm) ||
            needs(id_use_rd, id_rd));
  endfunction

  task automatic model_clear();
    m_ex = '0;
    m_cnt = 0;
    for (int a = 0; a < 3; a++) begin
      h_rd[a] = '0;
      h_rf[a] = 1'b0;
    end
  endtask

  task automatic tick();
    logic st;
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      st = exp_stall();
      for (int a = 2; a > 0; a--) begin
        h_rd[a] = h_rd[a-1];
        h_rf[a] = h_rf[a-1];
      end
      m_ex = (st || flush) ? ex_t'(0) : cur_in();
      h_rd[0] = m_ex.rd;
      h_rf[0] = m_ex.rf;
      if (st && !flush && m_cnt < MAXC) m_cnt++;
    end
    #1;
  endtask

  task automatic set_ins(input logic [3:0] alu, input logic [3:0] rd,
                         input logic rf, input logic ld,
                         input logic [3:0] rn, input logic urn,
                         input logic [3:0] rm, input logic urm,
                         input logic urd);
    id_alu_op = alu;     id_rd = rd;      id_rf_e = rf;
    id_load = ld;        id_rn = rn;      id_use_rn = urn;
    id_rm = rm;          id_use_rm = urm; id_use_rd = urd;
    id_am = 2'($urandom);
    id_mem_write = 1'($urandom);
    id_mem_size = 1'($urandom);
    id_mem_e = 1'($urandom);
    id_store_cc = 1'($urandom);
    id_pa = $urandom;
    id_pb = $urandom;
    id_pd = $urandom;
    id_shift_imm = 12'($urandom);
    flush = 1'b0;
  endtask

  task automatic set_nop();
    set_ins(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    set_nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_ins(4'b0100, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1, 1'b0);
    tick();
    checks++;
    if (dut_ex() !== ex_t'(0)) begin
      errors++;
      $display("FAIL reset_ex got %h want 0", dut_ex());
    end
    checks++;
    if ({fwd_a, fwd_b, fwd_d, pc_enable, ifid_enable, cu_mux_sel}
        !== 9'b000000_110) begin
      errors++;
      $display("FAIL reset_comb got %b want 000000110",
               {fwd_a, fwd_b, fwd_d, pc_enable, ifid_enable, cu_mux_sel});
    end
    checks++;
    if (stall_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", stall_count);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({ex_alu_op, ex_rf_e} !== 5'b0100_1) begin
      errors++;
      $display("FAIL reset_release got %b want 01001",
               {ex_alu_op, ex_rf_e});
    end
  endtask

  task automatic test_ex_forward();
    drain();
    set_ins(4'd4, 4'd1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    set_ins(4'd2, 4'd4, 1'b1, 1'b0, 4'd1, 1'b1, 4'd1, 1'b0, 1'b0);
    #1;
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0100) begin
      errors++;
      $display("FAIL fwd_ex got %b want 0100", {fwd_a, fwd_b});
    end
    tick();
    set_ins(4'd1, 4'd5, 1'b0, 1'b0, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (fwd_a !== 2'b10) begin
      errors++;
      $display("FAIL fwd_mem got %b want 10", fwd_a);
    end
    tick();
    #1;
    checks++;
    if (fwd_a !== 2'b11) begin
      errors++;
      $display("FAIL fwd_wb got %b want 11", fwd_a);
    end
  endtask

  task automatic test_priority();
    drain();
    set_ins(4'd4, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    set_ins(4'd4, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
    #1;
    checks++;
    if ({fwd_b, fwd_d} !== 4'b0101) begin
      errors++;
      $display("FAIL prio_ex got %b want 0101", {fwd_b, fwd_d});
    end
    drain();
    set_ins(4'd4, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    set_ins(4'd4, 4'd15, 1'b0, 1'b0, 4'd15, 1'b1, 4'd15, 1'b1, 1'b1);
    #1;
    checks++;
    if ({fwd_a, fwd_b, fwd_d} !== 6'b0) begin
      errors++;
      $display("FAIL prio_r15 got %b want 000000",
               {fwd_a, fwd_b, fwd_d});
    end
  endtask

  task automatic test_load_use();
    drain();
    set_ins(4'd4, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    set_ins(4'd4, 4'd6, 1'b1, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({pc_enable, ifid_enable, cu_mux_sel, fwd_a} !== 5'b001_00) begin
      errors++;
      $display("FAIL lu_stall got %b want 00100",
               {pc_enable, ifid_enable, cu_mux_sel, fwd_a});
    end
    tick();
    checks++;
    if (dut_ex() !== ex_t'(0)) begin
      errors++;
      $display("FAIL lu_bubble got %h want 0", dut_ex());
    end
    checks++;
    if (stall_count !== 2'd1) begin
      errors++;
      $display("FAIL lu_count got %0d want 1", stall_count);
    end
    checks++;
    if ({pc_enable, ifid_enable, cu_mux_sel, fwd_a} !== 5'b110_10) begin
      errors++;
      $display("FAIL lu_release got %b want 11010",
               {pc_enable, ifid_enable, cu_mux_sel, fwd_a});
    end
    tick();
    checks++;
    if ({ex_rd, ex_rf_e} !== 5'b0110_1) begin
      errors++;
      $display("FAIL lu_issue got %b want 01101", {ex_rd, ex_rf_e});
    end
  endtask

  task automatic test_flush_stall();
    drain();
    set_ins(4'd4, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    set_ins(4'd4, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if ({pc_enable, ifid_enable, cu_mux_sel} !== 3'b111) begin
      errors++;
      $display("FAIL fs_comb got %b want 111",
               {pc_enable, ifid_enable, cu_mux_sel});
    end
    tick();
    flush = 1'b0;
    checks++;
    if ({ex_rf_e, ex_rd, stall_count} !== 7'b0_0000_01) begin
      errors++;
      $display("FAIL fs_bubble got %b want 0000001",
               {ex_rf_e, ex_rd, stall_count});
    end
  endtask

  task automatic test_saturation_reset();
    drain();
    for (int i = 0; i < 5; i++) begin
      set_ins(4'd4, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
      set_ins(4'd4, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3 == 4'd3);
      id_rd = 4'd3;
      tick();
    end
    checks++;
    if (stall_count !== 2'd3) begin
      errors++;
      $display("FAIL sat_count got %0d want 3", stall_count);
    end
    set_ins(4'd4, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick();
    set_ins(4'd4, 4'd6, 1'b1, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (cu_mux_sel !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_stall got %b want 1", cu_mux_sel);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (dut_ex() !== ex_t'(0) || stall_count !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got %h/%0d want 0/0",
               dut_ex(), stall_count);
    end
    checks++;
    if ({pc_enable, ifid_enable, cu_mux_sel} !== 3'b110) begin
      errors++;
      $display("FAIL async_reset_ctl got %b want 110",
               {pc_enable, ifid_enable, cu_mux_sel});
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (pc_enable !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_pc got %b want 1", pc_enable);
    end
  endtask

  function automatic logic [3:0] rreg();
    case ($urandom_range(0, 4))
      0: return 4'd1;
      1: return 4'd2;
      2: return 4'd3;
      3: return 4'd15;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic test_random();
    logic [5:0] ef;
    logic       st;
    logic [2:0] ec;
    for (int i = 0; i < 400; i++) begin
      set_ins(4'($urandom), rreg(), $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 3, rreg(), 1'($urandom),
              rreg(), 1'($urandom), 1'($urandom));
      flush = $urandom_range(0, 9) == 0;
      #1;
      ef = {exp_fwd(id_use_rn, id_rn), exp_fwd(id_use_rm, id_rm),
            exp_fwd(id_use_rd, id_rd)};
      st = exp_stall();
      ec = {!st || flush, !st || flush, st};
      checks++;
      if ({fwd_a, fwd_b, fwd_d} !== ef) begin
        errors++;
        $display("FAIL rnd_fwd[%0d] got %b want %b", i,
                 {fwd_a, fwd_b, fwd_d}, ef);
      end
      checks++;
      if ({pc_enable, ifid_enable, cu_mux_sel} !== ec) begin
        errors++;
        $display("FAIL rnd_ctl[%0d] got %b want %b", i,
                 {pc_enable, ifid_enable, cu_mux_sel}, ec);
      end
      tick();
      checks++;
      if (dut_ex() !== m_ex) begin
        errors++;
        $display("FAIL rnd_ex[%0d] got %h want %h", i, dut_ex(), m_ex);
      end
      checks++;
      if (int'(stall_count) != m_cnt) begin
        errors++;
        $display("FAIL rnd_cnt[%0d] got %0d want %0d", i,
                 stall_count, m_cnt);
      end
    end
  endtask

  initial begin
    model_clear();
    reset = 1'b1;
    set_nop();
    test_reset();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_flush_stall();
    test_saturation_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
